// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared constants for the fetch / load-store memory arbiter:
//                FSM state encoding, requester IDs and width defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Width defaults for the shared byte-addressed memory port
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // FSM state encoding (3 bits for five states)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WR_LO = 3'd2;
  localparam logic [2:0] ST_WR_HI = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Requester identifiers, also used as the round-robin "last owner" value
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_rr2
//  Description : Combinational two-way round-robin picker. On contention the
//                requester that did not own the port last is granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant
);

  // Pick a winner: alternate on contention, otherwise take the lone requester
  always_comb begin
    grant_valid = req_if | req_ls;
    grant       = REQ_IF;
    if (req_if && req_ls) begin
      grant = (last_owner == REQ_LS) ? REQ_IF : REQ_LS;
    end else if (req_ls) begin
      grant = REQ_LS;
    end
  end

endmodule : mem_arb_rr2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one byte-wide-write memory port between an
//                instruction-fetch requester and a load/store requester.
//                Reads return a little-endian word; word stores are split into
//                two consecutive byte writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch requester
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  // load/store requester
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic                ls_word,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_done,
  // memory port
  output logic [ADDR_W-1:0]   Address,
  output logic                MemWrite,
  output logic [DATA_W/2-1:0] WD,
  input  logic [DATA_W-1:0]   RD,
  output logic                busy
);

  localparam int HALF_W = DATA_W / 2;

  logic [2:0]        r_state;
  logic              r_owner;      // owner of the current/last grant
  logic [ADDR_W-1:0] r_addr;
  logic              r_word;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_grant_valid;
  logic w_grant;

  mem_arb_rr2 u_rr2 (
    .req_if      (if_req),
    .req_ls      (ls_req),
    .last_owner  (r_owner),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  // Arbitration FSM with latched transaction and per-requester read data.
  // r_owner resets to REQ_IF so the first contended grant goes to load/store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= REQ_IF;
      r_addr     <= '0;
      r_word     <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant;
            if (w_grant == REQ_LS) begin
              r_addr  <= ls_addr;
              r_word  <= ls_word;
              r_wdata <= ls_wdata;
              r_state <= ls_we ? ST_WR_LO : ST_READ;
            end else begin
              r_addr  <= if_addr;
              r_word  <= 1'b0;
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_owner == REQ_LS) begin
            r_ls_rdata <= RD;
          end else begin
            r_if_rdata <= RD;
          end
          r_state <= ST_RESP;
        end
        ST_WR_LO: r_state <= r_word ? ST_WR_HI : ST_RESP;
        ST_WR_HI: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decode: address/write strobe/byte lane follow state only
  always_comb begin
    Address  = (r_state == ST_WR_HI) ? (r_addr + ADDR_W'(1)) : r_addr;
    MemWrite = (r_state == ST_WR_LO) || (r_state == ST_WR_HI);
    WD       = '0;
    if (r_state == ST_WR_LO) begin
      WD = r_wdata[HALF_W-1:0];
    end else if (r_state == ST_WR_HI) begin
      WD = r_wdata[DATA_W-1:HALF_W];
    end
  end

  assign if_done  = (r_state == ST_RESP) && (r_owner == REQ_IF);
  assign ls_done  = (r_state == ST_RESP) && (r_owner == REQ_LS);
  assign busy     = (r_state != ST_IDLE);
  assign if_rdata = r_if_rdata;
  assign ls_rdata = r_ls_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a byte memory
//                model and a scoreboard of expected memory writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic        ls_word;
  logic [7:0]  ls_addr;
  logic [15:0] ls_wdata;
  logic [15:0] ls_rdata;
  logic        ls_done;
  logic [7:0]  Address;
  logic        MemWrite;
  logic [7:0]  WD;
  logic [15:0] RD;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] mem [256];
  logic [7:0] addr_p1;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_word  (ls_word),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_rdata (ls_rdata),
    .ls_done  (ls_done),
    .Address  (Address),
    .MemWrite (MemWrite),
    .WD       (WD),
    .RD       (RD),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // memory model: combinational little-endian read, byte write on clock edge
  assign addr_p1 = Address + 8'd1;
  assign RD = {mem[addr_p1], mem[Address]};
  always @(posedge clk) begin
    if (MemWrite) mem[Address] <= WD;
  end

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (MemWrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %h data %h, required no write", Address, WD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (Address !== e.a || WD !== e.d) begin
          errors++;
          $display("FAIL wr_data: got addr %h data %h, required addr %h data %h",
                   Address, WD, e.a, e.d);
        end
      end
    end
  end

  // counts negedges until the selected done pulse is seen; -1 on timeout
  task automatic wait_done(input bit is_ls, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((is_ls && ls_done) || (!is_ls && if_done)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_word = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    #12;
    checks++;
    if ({busy, MemWrite, if_done, ls_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000", {busy, MemWrite, if_done, ls_done});
    end
    checks++;
    if (Address !== 8'h00 || WD !== 8'h00) begin
      errors++;
      $display("FAIL reset_port: got Address %h WD %h, required 00 00", Address, WD);
    end
    checks++;
    if (if_rdata !== 16'h0 || ls_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h, required 0000 0000", if_rdata, ls_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    int cyc;
    mem[8'h02] = 8'h05; mem[8'h03] = 8'hE4;
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h02;
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL fetch_latency: got %0d, required 2", cyc);
    end
    checks++;
    if (if_rdata !== 16'hE405) begin
      errors++;
      $display("FAIL fetch_rdata: got %h, required e405", if_rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: got busy %b done %b, required 0 0", busy, if_done);
    end
  endtask

  task automatic test_load();
    int cyc;
    mem[8'h50] = 8'h3C; mem[8'h51] = 8'h9A;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h50;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    checks++;
    if (cyc !== 2 || ls_rdata !== 16'h9A3C) begin
      errors++;
      $display("FAIL load: got cyc %0d data %h, required 2 9a3c", cyc, ls_rdata);
    end
    @(negedge clk);
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] d, input bit word,
                       output int cyc);
    exp_q.push_back('{a: a, d: d[7:0]});
    if (word) exp_q.push_back('{a: a + 8'd1, d: d[15:8]});
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_word = word; ls_addr = a; ls_wdata = d;
    wait_done(1'b1, cyc);
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int cyc;
    store(8'h28, 16'hBEEF, 1'b1, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL wstore_latency: got %0d, required 3", cyc);
    end
    checks++;
    if (mem[8'h28] !== 8'hEF || mem[8'h29] !== 8'hBE || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wstore_mem: got %h %h pending %0d, required ef be 0",
               mem[8'h28], mem[8'h29], exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    store(8'hFF, 16'h1234, 1'b1, cyc);
    checks++;
    if (cyc !== 3 || mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin
      errors++;
      $display("FAIL wrap: got cyc %0d mem %h %h, required 3 34 12",
               cyc, mem[8'hFF], mem[8'h00]);
    end
  endtask

  task automatic test_byte_store();
    int cyc;
    logic [15:0] prev;
    prev = ls_rdata;
    mem[8'h31] = 8'h77;
    store(8'h30, 16'hAA55, 1'b0, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL bstore_latency: got %0d, required 2", cyc);
    end
    checks++;
    if (mem[8'h30] !== 8'h55 || mem[8'h31] !== 8'h77 || ls_rdata !== prev) begin
      errors++;
      $display("FAIL bstore_mem: got %h %h rdata %h, required 55 77 %h",
               mem[8'h30], mem[8'h31], ls_rdata, prev);
    end
  endtask

  task automatic test_contention();
    int cyc;
    do_reset();
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22;
    mem[8'h10] = 8'h33; mem[8'h11] = 8'h44;
    // first contention after reset: load/store wins
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h04;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    checks++;
    if (cyc !== 2 || if_done !== 1'b0 || ls_rdata !== 16'h2211) begin
      errors++;
      $display("FAIL rr_first: got cyc %0d if_done %b data %h, required 2 0 2211",
               cyc, if_done, ls_rdata);
    end
    // fetch still pending: served right after (RESP, IDLE, READ, RESP)
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    checks++;
    if (cyc !== 3 || if_rdata !== 16'h4433) begin
      errors++;
      $display("FAIL rr_second: got cyc %0d data %h, required 3 4433", cyc, if_rdata);
    end
    @(negedge clk);
    // fetch was last: next contention goes to load/store
    if_req = 1'b1; ls_req = 1'b1;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL rr_third: got ls cyc %0d, required 2", cyc);
    end
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    @(negedge clk);
    // fetch was last again, fetch alone is granted at once
    if_req = 1'b1;
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL rr_single: got if cyc %0d, required 2", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wr_hi();
    int seen_done;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'h00;
    exp_q.push_back('{a: 8'h40, d: 8'hCD});
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_word = 1'b1; ls_addr = 8'h40; ls_wdata = 16'hABCD;
    @(negedge clk);            // WR_LO
    @(posedge clk);            // enters WR_HI
    #2;
    checks++;
    if (MemWrite !== 1'b1 || Address !== 8'h41) begin
      errors++;
      $display("FAIL wrhi_pre: got MemWrite %b Address %h, required 1 41", MemWrite, Address);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || busy !== 1'b0 || ls_done !== 1'b0) begin
      errors++;
      $display("FAIL wrhi_abort: got MemWrite %b busy %b done %b, required 0 0 0",
               MemWrite, busy, ls_done);
    end
    @(negedge clk);
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ls_done || if_done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0 || mem[8'h40] !== 8'hCD || mem[8'h41] !== 8'h00 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrhi_after: got activity %0d mem %h %h pending %0d, required 0 cd 00 0",
               seen_done, mem[8'h40], mem[8'h41], exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_fetch();
    test_load();
    test_word_store();
    test_wrap();
    test_byte_store();
    test_contention();
    test_reset_in_wr_hi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
